// File: rtl/elevator_request_scheduler.sv
// -----------------------------------------------------------------------------
// elevator_request_scheduler
//
// Single-car LOOK scheduler. Hall and cabin button presses are latched into a
// pending-request vector. The car keeps travelling in its current direction
// while requests remain ahead of it, then reverses. At each served floor the
// door is held open for a fixed dwell. The car is out of service while off_btn
// is high.
//
// Parameters
//   FLOORS       number of served floors, numbered 1..FLOORS (2..32)
//   DOOR_CYCLES  door-open dwell in clock cycles (>= 1)
//
// Ports
//   clock              rising-edge clock
//   reset              asynchronous, active-low reset
//   off_btn            level; car out of service while high
//   position           current floor from the car sensor (valid in 1..FLOORS)
//   floor_press_event  hall press, floor number for one cycle, 0 = none
//   cabin_press_event  cabin press, floor number for one cycle, 0 = none
//   motor_up           drive car upward
//   motor_down         drive car downward
//   door               door open command
//   target             nearest pending floor in the travel direction, 0 = none
//   pending            bit i-1 set means floor i is requested
//   busy               high in any state other than IDLE and OFF
// -----------------------------------------------------------------------------
module elevator_request_scheduler #(
  parameter int unsigned FLOORS      = 8,
  parameter int unsigned DOOR_CYCLES = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              off_btn,
  input  logic [31:0]       position,
  input  logic [31:0]       floor_press_event,
  input  logic [31:0]       cabin_press_event,
  output logic              motor_up,
  output logic              motor_down,
  output logic              door,
  output logic [31:0]       target,
  output logic [FLOORS-1:0] pending,
  output logic              busy
);

  localparam int unsigned   CW    = $clog2(DOOR_CYCLES + 1);
  localparam logic [CW-1:0] DWELL = CW'(DOOR_CYCLES);
  localparam logic [CW-1:0] ONE   = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR_OPEN,
    OFF
  } state_e;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_e;

  state_e            state_q, state_d;
  dir_e              dir_q,   dir_d;
  logic [CW-1:0]     cnt_q,   cnt_d;
  logic [FLOORS-1:0] pend_q,  pend_d;

  // Decoded views of the inputs against the floor numbering.
  logic [FLOORS-1:0] pos_mask;     // one-hot of position, all-zero if invalid
  logic [FLOORS-1:0] press_mask;   // floors pressed this cycle (either source)
  logic [FLOORS-1:0] capture_mask; // presses that actually set a pending bit
  logic              pos_valid;
  logic              at_pos;
  logic              above;
  logic              below;
  logic              ahead;
  logic              behind;
  logic              reload;

  // Target search results.
  logic [31:0]       up_hit;
  logic [31:0]       dn_hit;

  assign pending = pend_q;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  always_comb begin
    pos_mask   = '0;
    press_mask = '0;
    above      = 1'b0;
    below      = 1'b0;
    for (int unsigned i = 0; i < FLOORS; i++) begin
      pos_mask[i]   = (position == i + 1);
      press_mask[i] = (floor_press_event == i + 1) ||
                      (cabin_press_event == i + 1);
      if (pend_q[i] && ((i + 1) > position)) above = 1'b1;
      if (pend_q[i] && ((i + 1) < position)) below = 1'b1;
    end
  end

  assign pos_valid = |pos_mask;
  assign at_pos    = |(pend_q & pos_mask);
  assign ahead     = (dir_q == DIR_UP) ? above : below;
  assign behind    = (dir_q == DIR_UP) ? below : above;

  // With the door open, a press at the current floor extends the dwell
  // instead of queueing a request the car is already serving.
  assign reload       = (state_q == DOOR_OPEN) && |(press_mask & pos_mask);
  assign capture_mask = (state_q == DOOR_OPEN) ? (press_mask & ~pos_mask)
                                               : press_mask;

  // ---------------------------------------------------------------------------
  // Target: nearest pending floor in dir, else nearest in the other direction
  // ---------------------------------------------------------------------------
  always_comb begin
    up_hit = '0;
    dn_hit = '0;
    for (int unsigned i = 0; i < FLOORS; i++) begin
      // Ascending scan: first hit above is the lowest, last hit below the highest.
      if (pend_q[i] && ((i + 1) > position) && (up_hit == '0)) up_hit = i + 1;
      if (pend_q[i] && ((i + 1) < position))                   dn_hit = i + 1;
    end
    if (dir_q == DIR_UP) begin
      target = (up_hit != '0) ? up_hit : dn_hit;
    end else begin
      target = (dn_hit != '0) ? dn_hit : up_hit;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q | capture_mask;

    if (off_btn) begin
      state_d = OFF;
      pend_d  = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        OFF: begin
          // Presses in the cycle off_btn falls are still ignored.
          state_d = IDLE;
          pend_d  = '0;
        end

        IDLE: begin
          if (pos_valid) begin
            if (at_pos) begin
              state_d = DOOR_OPEN;
              cnt_d   = DWELL;
              pend_d  = pend_d & ~pos_mask;
            end else if (above) begin
              state_d = MOVE_UP;
              dir_d   = DIR_UP;
            end else if (below) begin
              state_d = MOVE_DOWN;
              dir_d   = DIR_DOWN;
            end
          end
        end

        MOVE_UP, MOVE_DOWN: begin
          if (at_pos) begin
            state_d = DOOR_OPEN;
            cnt_d   = DWELL;
            pend_d  = pend_d & ~pos_mask;
          end
        end

        DOOR_OPEN: begin
          if (reload) begin
            cnt_d = DWELL;
          end else if (cnt_q == ONE) begin
            if (ahead) begin
              state_d = (dir_q == DIR_UP) ? MOVE_UP : MOVE_DOWN;
              cnt_d   = '0;
            end else if (behind) begin
              state_d = (dir_q == DIR_UP) ? MOVE_DOWN : MOVE_UP;
              dir_d   = (dir_q == DIR_UP) ? DIR_DOWN  : DIR_UP;
              cnt_d   = '0;
            end else if (at_pos) begin
              cnt_d  = DWELL;
              pend_d = pend_d & ~pos_mask;
            end else begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and registered Moore outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      dir_q      <= DIR_UP;
      cnt_q      <= '0;
      pend_q     <= '0;
      motor_up   <= 1'b0;
      motor_down <= 1'b0;
      door       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      motor_up   <= (state_d == MOVE_UP);
      motor_down <= (state_d == MOVE_DOWN);
      door       <= (state_d == DOOR_OPEN);
      busy       <= (state_d != IDLE) && (state_d != OFF);
    end
  end

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for elevator_request_scheduler. Directed scenarios followed by a
// randomized phase, all compared every cycle against a behavioural car model
// (request set, motion direction, door time remaining).
// -----------------------------------------------------------------------------
module tb_elevator_request_scheduler;

  localparam int FLOORS      = 8;
  localparam int DOOR_CYCLES = 4;

  logic              clock;
  logic              reset;
  logic              off_btn;
  logic [31:0]       position;
  logic [31:0]       floor_press_event;
  logic [31:0]       cabin_press_event;
  logic              motor_up;
  logic              motor_down;
  logic              door;
  logic [31:0]       target;
  logic [FLOORS-1:0] pending;
  logic              busy;

  int checks;
  int failures;

  elevator_request_scheduler #(
    .FLOORS      (FLOORS),
    .DOOR_CYCLES (DOOR_CYCLES)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .off_btn           (off_btn),
    .position          (position),
    .floor_press_event (floor_press_event),
    .cabin_press_event (cabin_press_event),
    .motor_up          (motor_up),
    .motor_down        (motor_down),
    .door              (door),
    .target            (target),
    .pending           (pending),
    .busy              (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // Behavioural model of the car
  // ---------------------------------------------------------------------------
  bit req [1:FLOORS];  // requested floors
  int m_motion;        // +1 travelling up, -1 travelling down, 0 stopped
  int m_door_left;     // door-open cycles remaining, 0 = door closed
  int m_dir;           // last travel direction, +1 / -1
  bit m_off;

  task automatic model_reset();
    m_motion    = 0;
    m_door_left = 0;
    m_dir       = 1;
    m_off       = 1'b0;
    for (int f = 1; f <= FLOORS; f++) req[f] = 1'b0;
  endtask

  // Advance the model by one clock using the inputs presented this cycle.
  task automatic model_step();
    bit nreq [1:FLOORS];
    int p;
    int ev [2];
    bit valid, here, above, below, reload, fwd, back;
    p      = int'(position);
    ev[0]  = int'(floor_press_event);
    ev[1]  = int'(cabin_press_event);
    valid  = (p >= 1) && (p <= FLOORS);
    for (int f = 1; f <= FLOORS; f++) nreq[f] = req[f];

    if (off_btn) begin
      m_off       = 1'b1;
      m_motion    = 0;
      m_door_left = 0;
      for (int f = 1; f <= FLOORS; f++) nreq[f] = 1'b0;
    end else if (m_off) begin
      m_off = 1'b0;
      for (int f = 1; f <= FLOORS; f++) nreq[f] = 1'b0;
    end else begin
      reload = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (ev[k] >= 1 && ev[k] <= FLOORS) begin
          if (m_door_left > 0 && ev[k] == p) reload = 1'b1;
          else nreq[ev[k]] = 1'b1;
        end
      end
      above = 1'b0;
      below = 1'b0;
      for (int f = 1; f <= FLOORS; f++) begin
        if (req[f] && f > p) above = 1'b1;
        if (req[f] && f < p) below = 1'b1;
      end
      here = 1'b0;
      if (valid) here = req[p];
      fwd  = (m_dir > 0) ? above : below;
      back = (m_dir > 0) ? below : above;

      if (m_door_left > 0) begin
        if (reload) m_door_left = DOOR_CYCLES;
        else if (m_door_left == 1) begin
          if (fwd) begin
            m_motion = m_dir; m_door_left = 0;
          end else if (back) begin
            m_dir = -m_dir; m_motion = m_dir; m_door_left = 0;
          end else if (here) begin
            nreq[p] = 1'b0; m_door_left = DOOR_CYCLES;
          end else begin
            m_door_left = 0;
          end
        end else m_door_left--;
      end else if (m_motion != 0) begin
        if (here) begin
          m_motion = 0; m_door_left = DOOR_CYCLES; nreq[p] = 1'b0;
        end
      end else if (valid) begin
        if (here) begin
          m_door_left = DOOR_CYCLES; nreq[p] = 1'b0;
        end else if (above) begin
          m_motion = 1; m_dir = 1;
        end else if (below) begin
          m_motion = -1; m_dir = -1;
        end
      end
    end
    for (int f = 1; f <= FLOORS; f++) req[f] = nreq[f];
  endtask

  function automatic logic [31:0] exp_pending();
    logic [31:0] v;
    v = '0;
    for (int f = 1; f <= FLOORS; f++) if (req[f]) v[f-1] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] exp_target();
    int p;
    p = int'(position);
    if (m_dir > 0) begin
      for (int f = p + 1; f <= FLOORS; f++) if (req[f]) return 32'(f);
      for (int f = (p - 1 > FLOORS ? FLOORS : p - 1); f >= 1; f--) if (req[f]) return 32'(f);
    end else begin
      for (int f = (p - 1 > FLOORS ? FLOORS : p - 1); f >= 1; f--) if (req[f]) return 32'(f);
      for (int f = p + 1; f <= FLOORS; f++) if (req[f]) return 32'(f);
    end
    return 32'd0;
  endfunction

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("motor_up",   32'(motor_up),   32'(m_motion > 0));
    chk("motor_down", 32'(motor_down), 32'(m_motion < 0));
    chk("door",       32'(door),       32'(m_door_left > 0));
    chk("busy",       32'(busy),       32'((m_motion != 0) || (m_door_left > 0)));
    chk("pending",    32'(pending),    exp_pending());
    chk("target",     target,          exp_target());
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    #1;
    check_all();
  endtask

  // Count cycles the door stays high, starting from a sample where it is high.
  task automatic count_door(output int n);
    n = 0;
    while (door === 1'b1 && n < 30) begin
      n++;
      tick();
    end
  endtask

  task automatic clear_presses();
    floor_press_event = '0;
    cabin_press_event = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int n;
  int off_left;

  initial begin
    checks            = 0;
    failures          = 0;
    off_left          = 0;
    reset             = 1'b0;
    off_btn           = 1'b0;
    position          = 32'd1;
    floor_press_event = '0;
    cabin_press_event = '0;
    model_reset();

    repeat (2) @(posedge clock);
    #1;
    chk("rst_motor_up",   32'(motor_up),   32'd0);
    chk("rst_motor_down", 32'(motor_down), 32'd0);
    chk("rst_door",       32'(door),       32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_pending",    32'(pending),    32'd0);
    chk("rst_target",     target,          32'd0);
    reset = 1'b1;
    tick();

    // Cabin press 3 from floor 1, travel up and serve it.
    cabin_press_event = 32'd3;
    tick();
    clear_presses();
    chk("A_pending",     32'(pending),  32'b100);
    chk("A_motor_early", 32'(motor_up), 32'd0);
    tick();
    chk("A_motor_up", 32'(motor_up), 32'd1);
    chk("A_target",   target,        32'd3);
    tick();
    position = 32'd2; tick();
    position = 32'd3; tick();
    chk("A_arrive_door",  32'(door),     32'd1);
    chk("A_arrive_motor", 32'(motor_up), 32'd0);
    chk("A_arrive_pend",  32'(pending),  32'd0);
    count_door(n);
    chk("A_dwell",     32'(n),    32'd4);
    chk("A_idle_busy", 32'(busy), 32'd0);

    // Floor 2, presses 5 and 1 together: up to 5, then down to 1.
    position          = 32'd2;
    floor_press_event = 32'd5;
    cabin_press_event = 32'd1;
    tick();
    clear_presses();
    chk("B_pending", 32'(pending), 32'b10001);
    tick();
    chk("B_motor_up", 32'(motor_up), 32'd1);
    chk("B_target5",  target,        32'd5);
    position = 32'd3; tick();
    position = 32'd4; tick();
    position = 32'd5; tick();
    chk("B_door5", 32'(door), 32'd1);
    count_door(n);
    chk("B_dwell5",   32'(n),          32'd4);
    chk("B_no_gap",   32'(motor_down), 32'd1);
    chk("B_target1",  target,          32'd1);
    position = 32'd4; tick();
    position = 32'd3; tick();
    position = 32'd2; tick();
    position = 32'd1; tick();
    chk("B_door1", 32'(door), 32'd1);
    count_door(n);
    chk("B_dwell1", 32'(n), 32'd4);

    // Up toward 6, hall 4 picked up on the way; later press 2 waits until after 6.
    cabin_press_event = 32'd6;
    tick();
    clear_presses();
    tick();
    chk("C_motor_up", 32'(motor_up), 32'd1);
    position = 32'd2; tick();
    position = 32'd3;
    floor_press_event = 32'd4;
    tick();
    clear_presses();
    chk("C_pending", 32'(pending), 32'b101000);
    position = 32'd4; tick();
    chk("C_stop4", 32'(door), 32'd1);
    count_door(n);
    chk("C_dwell4",   32'(n),        32'd4);
    chk("C_resume",   32'(motor_up), 32'd1);
    cabin_press_event = 32'd2;
    tick();
    clear_presses();
    position = 32'd5; tick();
    position = 32'd6; tick();
    chk("C_stop6",    32'(door), 32'd1);
    chk("C_target2",  target,    32'd2);
    count_door(n);
    chk("C_dwell6",   32'(n),          32'd4);
    chk("C_reverse",  32'(motor_down), 32'd1);
    position = 32'd5; tick();
    position = 32'd4; tick();
    position = 32'd3; tick();
    position = 32'd2; tick();
    chk("C_stop2", 32'(door), 32'd1);
    count_door(n);

    // Door reload at floor 4.
    position          = 32'd4;
    cabin_press_event = 32'd4;
    tick();
    clear_presses();
    tick();
    chk("D_door", 32'(door), 32'd1);
    tick();
    tick();
    cabin_press_event = 32'd4;
    tick();
    clear_presses();
    chk("D_pend_clear", 32'(pending), 32'd0);
    count_door(n);
    chk("D_reload_dwell", 32'(n), 32'd4);

    // Out-of-range presses.
    floor_press_event = 32'd0;
    cabin_press_event = 32'd9;
    tick();
    floor_press_event = 32'd9;
    cabin_press_event = 32'd0;
    tick();
    clear_presses();
    chk("E_pending", 32'(pending), 32'd0);
    chk("E_busy",    32'(busy),    32'd0);

    // Out of service while moving.
    position          = 32'd1;
    floor_press_event = 32'd2;
    cabin_press_event = 32'd4;
    tick();
    clear_presses();
    chk("F_pending", 32'(pending), 32'b1010);
    tick();
    chk("F_moving", 32'(motor_up), 32'd1);
    off_btn = 1'b1;
    tick();
    chk("F_off_motor", 32'(motor_up), 32'd0);
    chk("F_off_pend",  32'(pending),  32'd0);
    chk("F_off_busy",  32'(busy),     32'd0);
    floor_press_event = 32'd3;
    tick();
    clear_presses();
    chk("F_off_ignore", 32'(pending), 32'd0);
    off_btn           = 1'b0;
    cabin_press_event = 32'd5;
    tick();
    clear_presses();
    chk("F_back_pend", 32'(pending), 32'd0);
    chk("F_back_busy", 32'(busy),    32'd0);
    tick();

    // Asynchronous reset while the door is open.
    position          = 32'd2;
    cabin_press_event = 32'd2;
    tick();
    clear_presses();
    tick();
    chk("G_door", 32'(door), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("G_async_door", 32'(door),    32'd0);
    chk("G_async_busy", 32'(busy),    32'd0);
    chk("G_async_pend", 32'(pending), 32'd0);
    chk("G_async_tgt",  target,       32'd0);
    model_reset();
    #1 reset = 1'b1;
    tick();

    // Randomized traffic with a car that follows the commanded motion.
    for (int c = 0; c < 600; c++) begin
      floor_press_event = ($urandom_range(0, 2) == 0) ? $urandom_range(0, FLOORS + 1) : 0;
      cabin_press_event = ($urandom_range(0, 2) == 0) ? $urandom_range(0, FLOORS + 1) : 0;
      if (off_left == 0 && $urandom_range(0, 79) == 0) off_left = int'($urandom_range(1, 3));
      off_btn = (off_left != 0);
      if (off_left != 0) off_left--;
      if (c % 3 == 0) begin
        if (m_motion > 0 && position < FLOORS)      position = position + 32'd1;
        else if (m_motion < 0 && position > 32'd1)  position = position - 32'd1;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
